// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between pipeline control, producer stage and the
// inter-stage register.
interface pipe_stage_reg_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned AUXW   = 8,
  parameter int unsigned SCW    = 64,
  parameter int unsigned CNTW   = 2,
  parameter int unsigned STALLW = 6,
  parameter int unsigned BCW    = 16
);
  logic [STALLW-1:0] stall;
  logic              flush;
  logic              in_valid;
  logic [AW-1:0]     in_wd;
  logic              in_wreg;
  logic [DW-1:0]     in_wdata;
  logic [DW-1:0]     in_hi;
  logic [DW-1:0]     in_lo;
  logic              in_whilo;
  logic [AUXW-1:0]   in_aux;
  logic [SCW-1:0]    scratch_i;
  logic [CNTW-1:0]   cnt_i;
  logic              out_valid;
  logic [AW-1:0]     out_wd;
  logic              out_wreg;
  logic [DW-1:0]     out_wdata;
  logic [DW-1:0]     out_hi;
  logic [DW-1:0]     out_lo;
  logic              out_whilo;
  logic [AUXW-1:0]   out_aux;
  logic [SCW-1:0]    scratch_o;
  logic [CNTW-1:0]   cnt_o;
  logic [BCW-1:0]    bubble_cnt;

  // Producer/control side
  modport master (
    output stall, flush, in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo,
           in_whilo, in_aux, scratch_i, cnt_i,
    input  out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo,
           out_aux, scratch_o, cnt_o, bubble_cnt
  );

  // Pipeline register side
  modport slave (
    input  stall, flush, in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo,
           in_whilo, in_aux, scratch_i, cnt_i,
    output out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo,
           out_aux, scratch_o, cnt_o, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/flush, scratch
// feedback to a stalled producer and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned AUXW    = 8,
  parameter int unsigned SCW     = 64,
  parameter int unsigned CNTW    = 2,
  parameter int unsigned STALLW  = 6,
  parameter int unsigned STAGE   = 3,
  parameter int unsigned HILO_EN = 1,
  parameter int unsigned BCW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipe_stage_reg_if.slave bus
);

  logic w_up;
  logic w_dn;
  logic w_load;
  logic w_clr;
  logic w_fb;
  logic w_bubble;

  logic            r_valid;
  logic [AW-1:0]   r_wd;
  logic            r_wreg;
  logic [DW-1:0]   r_wdata;
  logic [AUXW-1:0] r_aux;
  logic [SCW-1:0]  r_scratch;
  logic [CNTW-1:0] r_cnt;
  logic [BCW-1:0]  r_bubble;

  assign w_up = bus.stall[STAGE];
  assign w_dn = bus.stall[STAGE+1];

  // Flush and reset dominate; a lone dn without up still advances.
  assign w_load   = !rst && !bus.flush && !w_up;
  assign w_clr    = rst || bus.flush || (w_up && !w_dn);
  assign w_fb     = !rst && !bus.flush && w_up;
  assign w_bubble = !rst && !bus.flush && w_up && !w_dn;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
      r_aux   <= '0;
    end else if (w_load) begin
      r_valid <= bus.in_valid;
      r_wd    <= bus.in_wd;
      r_wreg  <= bus.in_wreg;
      r_wdata <= bus.in_wdata;
      r_aux   <= bus.in_aux;
    end
  end

  // Scratch is only meaningful while the producer is held; otherwise zero.
  always_ff @(posedge clk) begin
    if (w_fb) begin
      r_scratch <= bus.scratch_i;
      r_cnt     <= bus.cnt_i;
    end else begin
      r_scratch <= '0;
      r_cnt     <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble <= '0;
    end else if (w_bubble && (r_bubble != '1)) begin
      r_bubble <= r_bubble + BCW'(1);
    end
  end

  generate
    if (HILO_EN != 0) begin : g_hilo
      logic          r_whilo;
      logic [DW-1:0] r_hi;
      logic [DW-1:0] r_lo;

      always_ff @(posedge clk) begin
        if (w_clr) begin
          r_whilo <= 1'b0;
          r_hi    <= '0;
          r_lo    <= '0;
        end else if (w_load) begin
          r_whilo <= bus.in_whilo;
          r_hi    <= bus.in_hi;
          r_lo    <= bus.in_lo;
        end
      end

      assign bus.out_whilo = r_whilo;
      assign bus.out_hi    = r_hi;
      assign bus.out_lo    = r_lo;
    end else begin : g_no_hilo
      assign bus.out_whilo = 1'b0;
      assign bus.out_hi    = '0;
      assign bus.out_lo    = '0;
    end
  endgenerate

  assign bus.out_valid  = r_valid;
  assign bus.out_wd     = r_wd;
  assign bus.out_wreg   = r_wreg;
  assign bus.out_wdata  = r_wdata;
  assign bus.out_aux    = r_aux;
  assign bus.scratch_o  = r_scratch;
  assign bus.cnt_o      = r_cnt;
  assign bus.bubble_cnt = r_bubble;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus randomized check of pipe_stage_reg against a rule-level model;
// u0 uses default parameters, u1 uses BCW=4 and HILO_EN=0.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.BCW(16)) if0 ();
  pipe_stage_reg_if #(.BCW(4))  if1 ();

  pipe_stage_reg #(.BCW(16), .HILO_EN(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  pipe_stage_reg #(.BCW(4),  .HILO_EN(0)) u1 (.clk(clk), .rst(rst), .bus(if1));

  logic [5:0]  s_stall;
  logic        s_flush, s_valid, s_wreg, s_whilo;
  logic [4:0]  s_wd;
  logic [31:0] s_wdata, s_hi, s_lo;
  logic [7:0]  s_aux;
  logic [63:0] s_scr;
  logic [1:0]  s_cnt;

  assign if0.stall = s_stall;    assign if1.stall = s_stall;
  assign if0.flush = s_flush;    assign if1.flush = s_flush;
  assign if0.in_valid = s_valid; assign if1.in_valid = s_valid;
  assign if0.in_wd = s_wd;       assign if1.in_wd = s_wd;
  assign if0.in_wreg = s_wreg;   assign if1.in_wreg = s_wreg;
  assign if0.in_wdata = s_wdata; assign if1.in_wdata = s_wdata;
  assign if0.in_hi = s_hi;       assign if1.in_hi = s_hi;
  assign if0.in_lo = s_lo;       assign if1.in_lo = s_lo;
  assign if0.in_whilo = s_whilo; assign if1.in_whilo = s_whilo;
  assign if0.in_aux = s_aux;     assign if1.in_aux = s_aux;
  assign if0.scratch_i = s_scr;  assign if1.scratch_i = s_scr;
  assign if0.cnt_i = s_cnt;      assign if1.cnt_i = s_cnt;

  typedef struct {
    bit          valid, wreg, whilo;
    bit [4:0]    wd;
    bit [31:0]   wdata, hi, lo;
    bit [7:0]    aux;
    bit [63:0]   scr;
    bit [1:0]    cnt;
    int unsigned bub;
  } exp_t;

  exp_t e0, e1;
  int n_checks = 0;
  int n_err = 0;

  // Expected state after one clock, from the behavioural rules.
  function automatic exp_t next_exp(exp_t e, bit hilo, int unsigned bmax);
    exp_t n;
    bit up, dn;
    n = e;
    up = s_stall[3];
    dn = s_stall[4];
    if (rst) begin
      n = '{default: 0};
    end else if (s_flush) begin
      n = '{default: 0};
      n.bub = e.bub;
    end else if (!up) begin
      n.valid = s_valid; n.wd = s_wd; n.wreg = s_wreg; n.wdata = s_wdata;
      n.aux = s_aux;
      n.hi = hilo ? s_hi : 32'h0;
      n.lo = hilo ? s_lo : 32'h0;
      n.whilo = hilo ? s_whilo : 1'b0;
      n.scr = '0; n.cnt = '0;
    end else begin
      if (!dn) begin
        n = '{default: 0};
        n.bub = (e.bub < bmax) ? e.bub + 1 : e.bub;
      end
      n.scr = s_scr;
      n.cnt = s_cnt;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if0(input string p);
    chk({p, ".u0.valid"}, 64'(if0.out_valid), 64'(e0.valid));
    chk({p, ".u0.wd"},    64'(if0.out_wd),    64'(e0.wd));
    chk({p, ".u0.wreg"},  64'(if0.out_wreg),  64'(e0.wreg));
    chk({p, ".u0.wdata"}, 64'(if0.out_wdata), 64'(e0.wdata));
    chk({p, ".u0.hi"},    64'(if0.out_hi),    64'(e0.hi));
    chk({p, ".u0.lo"},    64'(if0.out_lo),    64'(e0.lo));
    chk({p, ".u0.whilo"}, 64'(if0.out_whilo), 64'(e0.whilo));
    chk({p, ".u0.aux"},   64'(if0.out_aux),   64'(e0.aux));
    chk({p, ".u0.scr"},   if0.scratch_o,      e0.scr);
    chk({p, ".u0.cnt"},   64'(if0.cnt_o),     64'(e0.cnt));
    chk({p, ".u0.bub"},   64'(if0.bubble_cnt), 64'(e0.bub));
  endtask

  task automatic chk_if1(input string p);
    chk({p, ".u1.valid"}, 64'(if1.out_valid), 64'(e1.valid));
    chk({p, ".u1.wd"},    64'(if1.out_wd),    64'(e1.wd));
    chk({p, ".u1.wdata"}, 64'(if1.out_wdata), 64'(e1.wdata));
    chk({p, ".u1.hi"},    64'(if1.out_hi),    64'(e1.hi));
    chk({p, ".u1.whilo"}, 64'(if1.out_whilo), 64'(e1.whilo));
    chk({p, ".u1.scr"},   if1.scratch_o,      e1.scr);
    chk({p, ".u1.cnt"},   64'(if1.cnt_o),     64'(e1.cnt));
    chk({p, ".u1.bub"},   64'(if1.bubble_cnt), 64'(e1.bub));
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later.
  task automatic step(input string p);
    @(posedge clk);
    e0 = next_exp(e0, 1'b1, 16'hFFFF);
    e1 = next_exp(e1, 1'b0, 15);
    #1;
    chk_if0(p);
    chk_if1(p);
  endtask

  task automatic rnd_inputs();
    s_valid = 1'($urandom); s_wreg = 1'($urandom); s_whilo = 1'($urandom);
    s_wd = 5'($urandom); s_wdata = $urandom; s_hi = $urandom; s_lo = $urandom;
    s_aux = 8'($urandom); s_scr = {$urandom, $urandom}; s_cnt = 2'($urandom);
  endtask

  initial begin
    e0 = '{default: 0};
    e1 = '{default: 0};
    rst = 1'b1; s_flush = 1'b0; s_stall = 6'h3F;
    rnd_inputs();
    step("reset0");
    rnd_inputs(); s_flush = 1'b1;
    step("reset1");
    chk("reset.bub_zero", 64'(if0.bubble_cnt), 64'd0);

    // Advance
    rst = 1'b0; s_flush = 1'b0; s_stall = 6'b000000;
    s_valid = 1'b1; s_wd = 5'd5; s_wdata = 32'hDEADBEEF; s_whilo = 1'b1;
    s_hi = 32'h11; s_lo = 32'h22; s_wreg = 1'b1; s_aux = 8'h3C;
    step("advance");
    chk("advance.wdata_const", 64'(if0.out_wdata), 64'hDEADBEEF);

    // Multi-cycle bubble
    s_stall = 6'b001111; s_scr = 64'h0000_0001_0000_0002; s_cnt = 2'd1;
    step("bubble0");
    s_cnt = 2'd2;
    step("bubble1");
    chk("bubble.cnt_const", 64'(if0.cnt_o), 64'd2);
    chk("bubble.bub_const", 64'(if0.bubble_cnt), 64'd2);
    s_stall = 6'b000000; rnd_inputs();
    step("bubble_exit");

    // Hold
    s_wd = 5'd7; s_wdata = 32'hA5A5A5A5; s_valid = 1'b1;
    step("hold_load");
    s_stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rnd_inputs();
      step("hold");
    end
    chk("hold.wdata_const", 64'(if0.out_wdata), 64'hA5A5A5A5);

    // Flush during bubble
    s_stall = 6'b001111; s_cnt = 2'd1; rnd_inputs(); s_cnt = 2'd1;
    step("flush_pre");
    s_flush = 1'b1;
    step("flush");
    chk("flush.cnt_const", 64'(if0.cnt_o), 64'd0);
    s_flush = 1'b0;

    // Saturation on the 4-bit counter
    s_stall = 6'b001111;
    for (int i = 0; i < 20; i++) begin
      rnd_inputs();
      step("saturate");
    end
    chk("saturate.u1_bub_const", 64'(if1.bubble_cnt), 64'd15);

    // HI/LO disabled instance ignores in_hi/in_whilo
    s_stall = 6'b000000; rnd_inputs(); s_hi = 32'hFFFFFFFF; s_whilo = 1'b1;
    step("nohilo");
    chk("nohilo.u1_hi_const", 64'(if1.out_hi), 64'd0);
    chk("nohilo.u0_hi_const", 64'(if0.out_hi), 64'hFFFFFFFF);

    // Random mix, including the illegal dn-without-up pattern
    for (int i = 0; i < 300; i++) begin
      rnd_inputs();
      s_stall = 6'($urandom);
      s_flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the generalised successor of the fixed EX->MEM latch.
- Carries register-write, HI/LO-write and auxiliary payload from producer stage STAGE to consumer stage STAGE+1.
- Honours the central stall vector and adds a pipeline flush input.
- Feeds multi-cycle scratch state (accumulate/divide partials, iteration counter) back to the producer while that stage is stalled, and counts inserted bubbles for performance monitoring.

Parameters:
- DW, 32, data word width (wdata, hi, lo)
- AW, 5, destination register address width
- AUXW, 8, extra payload width (e.g. aluop, mem control); 0 not allowed
- SCW, 64, scratch feedback width
- CNTW, 2, scratch iteration counter width
- STALLW, 6, stall vector width
- STAGE, 3, index of producer stage in stall vector; STAGE+1 < STALLW required
- HILO_EN, 1, 1 = HI/LO path present; 0 = HI/LO outputs constant zero
- BCW, 16, bubble counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  STALLW  stall vector from pipeline control; 1 = stop
- flush  in  1  kill the in-flight entry (exception/redirect)
- in_valid  in  1  producer has a real instruction
- in_wd  in  AW  destination register
- in_wreg  in  1  register write enable
- in_wdata  in  DW  register write data
- in_hi  in  DW  HI write data
- in_lo  in  DW  LO write data
- in_whilo  in  1  HI/LO write enable
- in_aux  in  AUXW  auxiliary payload
- scratch_i  in  SCW  producer scratch state
- cnt_i  in  CNTW  producer iteration counter
- out_valid  out  1  registered valid
- out_wd  out  AW  registered destination
- out_wreg  out  1  registered write enable
- out_wdata  out  DW  registered data
- out_hi  out  DW  registered HI
- out_lo  out  DW  registered LO
- out_whilo  out  1  registered HI/LO enable
- out_aux  out  AUXW  registered payload
- scratch_o  out  SCW  scratch returned to producer
- cnt_o  out  CNTW  counter returned to producer
- bubble_cnt  out  BCW  saturating count of inserted bubbles

Behaviour:
- Let up = stall[STAGE], dn = stall[STAGE+1].
- All outputs registered on posedge clk. Each cycle, exactly one action applies, highest priority first:
  1. rst=1: all outputs 0, including bubble_cnt. out_wd = NOP address (0).
  2. flush=1: payload cleared (valid, wreg, whilo, wd, wdata, hi, lo, aux = 0); scratch_o and cnt_o = 0, aborting any multi-cycle op. bubble_cnt unchanged. Flush overrides stall.
  3. Bubble, up=1 and dn=0: payload cleared as in flush; scratch_o <= scratch_i, cnt_o <= cnt_i; bubble_cnt += 1, saturating at all-ones with no wrap.
  4. Advance, up=0: payload <= inputs (out_valid <= in_valid). scratch_o and cnt_o = 0. This applies regardless of dn: control never asserts dn without up. If it does, advance takes effect anyway.
  5. Hold, up=1 and dn=1: payload retains its value; scratch_o <= scratch_i, cnt_o <= cnt_i.
- Latency: one cycle input-to-output on advance. Scratch feedback also takes one cycle.
- HILO_EN=0: out_hi, out_lo and out_whilo are driven constant 0, and in_hi, in_lo and in_whilo are ignored.
- in_valid=0 on advance: payload still registered verbatim. The consumer qualifies writes with out_valid.
- Reset or flush in the middle of a multi-cycle op clears cnt_o. The producer restarts from count 0.
- bubble_cnt is cleared only by rst.

Test Plan:
- Reset: rst=1 with random inputs for 2 cycles -> every output 0, bubble_cnt=0.
- Advance: stall=0, in_valid=1, in_wd=5, in_wdata=0xDEADBEEF, in_whilo=1, in_hi=0x11, in_lo=0x22 -> next cycle outputs equal inputs; scratch_o=0, cnt_o=0.
- Multi-cycle bubble: stall=6'b001111 (up=1, dn=0) for 2 cycles with scratch_i=0x0000_0001_0000_0002, cnt_i=1 then 2 -> payload zero each cycle, scratch_o tracks scratch_i, cnt_o=1 then 2, bubble_cnt=2. Then stall=0 -> new payload latched, cnt_o=0.
- Hold: load wd=7, wdata=0xA5A5A5A5, then stall=6'b011111 for 3 cycles -> payload unchanged, bubble_cnt unchanged, scratch_o follows scratch_i.
- Flush priority: during bubble with cnt_i=1, assert flush=1 -> payload 0, cnt_o=0, scratch_o=0, bubble_cnt not incremented.
- Saturation and HILO_EN=0: BCW=4, 20 bubble cycles -> bubble_cnt=15. With HILO_EN=0, in_hi=0xFFFFFFFF, in_whilo=1 on advance -> out_hi=0, out_whilo=0.
